// File: rtl/ext_mem_loader_if.sv
// ---------------------------------------------------------------------------
// ext_mem_loader_if
// Bundles the serial byte streams and the external memory port of
// ext_mem_loader.
//   rx_*     : command bytes in (valid/ready)
//   tx_*     : response bytes out (valid/ready)
//   pause    : processor halt request
//   external*: memory port ownership, address, write data, mode codes,
//              read data
// slave  = the loader itself; master = the environment driving it.
// ---------------------------------------------------------------------------
interface ext_mem_loader_if;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        pause;
   logic        externalMemoryControl;
   logic [31:0] externalAddress;
   logic [31:0] externalData;
   logic [2:0]  externalReadMode;
   logic [2:0]  externalWriteMode;
   logic [31:0] externalDataOut;

   modport slave (
      input  rx_data, rx_valid, tx_ready, externalDataOut,
      output rx_ready, tx_data, tx_valid, pause, externalMemoryControl,
             externalAddress, externalData, externalReadMode, externalWriteMode
   );

   modport master (
      output rx_data, rx_valid, tx_ready, externalDataOut,
      input  rx_ready, tx_data, tx_valid, pause, externalMemoryControl,
             externalAddress, externalData, externalReadMode, externalWriteMode
   );
endinterface

// File: rtl/ext_mem_loader.sv
// ---------------------------------------------------------------------------
// ext_mem_loader
// Byte-command front end that halts the processor and reads/writes words of
// external memory on its behalf.
//   'W' a3 a2 a1 a0 d3 d2 d1 d0 : word write, answers 'K'
//   'R' a3 a2 a1 a0             : word read, answers 4 data bytes MSB first
//   'G' / 'H'                   : release / halt processor, answers 'K'
//   anything else, or a stalled command : answers '?'
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - ext_mem_loader_if.slave (serial rx/tx, pause, memory port)
// Every output comes straight from a register.
// ---------------------------------------------------------------------------
module ext_mem_loader #(
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int READ_LATENCY   = 2        // 1..15
) (
   input  logic             clk,
   input  logic             rst,
   ext_mem_loader_if.slave  bus
);

   // Memory mode codes; only NONE and WORD are ever issued.
   localparam logic [2:0] MODE_NONE = 3'd0;
   localparam logic [2:0] MODE_WORD = 3'd3;

   localparam logic [7:0] OP_W   = 8'h57;
   localparam logic [7:0] OP_R   = 8'h52;
   localparam logic [7:0] OP_G   = 8'h47;
   localparam logic [7:0] OP_H   = 8'h48;
   localparam logic [7:0] RSP_OK = 8'h4B;
   localparam logic [7:0] RSP_ER = 8'h3F;

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_DATA, S_WRITE, S_READ, S_SEND, S_ACK
   } state_t;

   state_t        r_state, w_state;
   logic          r_is_wr, w_is_wr;
   logic [1:0]    r_cnt, w_cnt;
   logic [TW-1:0] r_tmo, w_tmo;
   logic [3:0]    r_lat, w_lat;
   logic [31:0]   r_rdata, w_rdata;
   logic [31:0]   r_addr, w_addr;
   logic [31:0]   r_data, w_data;
   logic          r_pause, w_pause;
   logic          r_mc, w_mc;
   logic [2:0]    r_rmode, w_rmode;
   logic [2:0]    r_wmode, w_wmode;
   logic [7:0]    r_tx_data, w_tx_data;
   logic          r_tx_valid, w_tx_valid;
   logic          r_rx_ready, w_rx_ready;

   logic          w_rx_acc, w_tx_acc, w_tmo_hit;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_is_wr    <= 1'b0;
         r_cnt      <= 2'd0;
         r_tmo      <= '0;
         r_lat      <= 4'd0;
         r_rdata    <= 32'd0;
         r_addr     <= 32'd0;
         r_data     <= 32'd0;
         r_pause    <= 1'b1;
         r_mc       <= 1'b1;
         r_rmode    <= MODE_NONE;
         r_wmode    <= MODE_NONE;
         r_tx_data  <= 8'd0;
         r_tx_valid <= 1'b0;
         r_rx_ready <= 1'b0;
      end else begin
         r_state    <= w_state;
         r_is_wr    <= w_is_wr;
         r_cnt      <= w_cnt;
         r_tmo      <= w_tmo;
         r_lat      <= w_lat;
         r_rdata    <= w_rdata;
         r_addr     <= w_addr;
         r_data     <= w_data;
         r_pause    <= w_pause;
         r_mc       <= w_mc;
         r_rmode    <= w_rmode;
         r_wmode    <= w_wmode;
         r_tx_data  <= w_tx_data;
         r_tx_valid <= w_tx_valid;
         r_rx_ready <= w_rx_ready;
      end
   end

   always_comb begin
      w_state    = r_state;
      w_is_wr    = r_is_wr;
      w_cnt      = r_cnt;
      w_tmo      = r_tmo;
      w_lat      = r_lat;
      w_rdata    = r_rdata;
      w_addr     = r_addr;
      w_data     = r_data;
      w_pause    = r_pause;
      w_mc       = r_mc;
      w_rmode    = r_rmode;
      w_wmode    = r_wmode;
      w_tx_data  = r_tx_data;
      w_tx_valid = r_tx_valid;

      w_rx_acc  = bus.rx_valid && r_rx_ready;
      w_tx_acc  = r_tx_valid && bus.tx_ready;
      w_tmo_hit = (r_tmo == TW'(TIMEOUT_CYCLES - 1));

      case (r_state)
         S_IDLE: begin
            if (w_rx_acc) begin
               case (bus.rx_data)
                  OP_W, OP_R: begin
                     w_is_wr = (bus.rx_data == OP_W);
                     w_pause = 1'b1;
                     w_mc    = 1'b1;
                     w_cnt   = 2'd0;
                     w_tmo   = '0;
                     w_state = S_ADDR;
                  end
                  OP_G: begin
                     w_pause    = 1'b0;
                     w_mc       = 1'b0;
                     w_tx_data  = RSP_OK;
                     w_tx_valid = 1'b1;
                     w_state    = S_ACK;
                  end
                  OP_H: begin
                     w_pause    = 1'b1;
                     w_mc       = 1'b1;
                     w_tx_data  = RSP_OK;
                     w_tx_valid = 1'b1;
                     w_state    = S_ACK;
                  end
                  default: begin
                     w_tx_data  = RSP_ER;
                     w_tx_valid = 1'b1;
                     w_state    = S_ACK;
                  end
               endcase
            end
         end

         // Address and data fields share the byte counter and the idle timer.
         S_ADDR, S_DATA: begin
            if (w_rx_acc) begin
               w_tmo = '0;
               w_cnt = r_cnt + 2'd1;
               if (r_state == S_ADDR) w_addr = {r_addr[23:0], bus.rx_data};
               else                   w_data = {r_data[23:0], bus.rx_data};
               if (r_cnt == 2'd3) begin
                  if (r_state == S_DATA) begin
                     w_state = S_WRITE;
                     w_wmode = MODE_WORD;
                  end else if (r_is_wr) begin
                     w_state = S_DATA;
                  end else begin
                     w_state = S_READ;
                     w_rmode = MODE_WORD;
                     w_lat   = 4'd0;
                  end
               end
            end else if (w_tmo_hit) begin
               // Abandon the command; the processor stays halted.
               w_tx_data  = RSP_ER;
               w_tx_valid = 1'b1;
               w_state    = S_ACK;
            end else begin
               w_tmo = r_tmo + TW'(1);
            end
         end

         S_WRITE: begin
            w_wmode    = MODE_NONE;
            w_tx_data  = RSP_OK;
            w_tx_valid = 1'b1;
            w_state    = S_ACK;
         end

         S_READ: begin
            if (r_lat == 4'(READ_LATENCY - 1)) begin
               // First byte goes straight to tx; the rest queue up in r_rdata.
               w_rmode    = MODE_NONE;
               w_tx_data  = bus.externalDataOut[31:24];
               w_rdata    = {bus.externalDataOut[23:0], 8'h00};
               w_tx_valid = 1'b1;
               w_cnt      = 2'd0;
               w_state    = S_SEND;
            end else begin
               w_lat = r_lat + 4'd1;
            end
         end

         S_SEND: begin
            if (w_tx_acc) begin
               if (r_cnt == 2'd3) begin
                  w_tx_valid = 1'b0;
                  w_state    = S_IDLE;
               end else begin
                  w_cnt     = r_cnt + 2'd1;
                  w_tx_data = r_rdata[31:24];
                  w_rdata   = {r_rdata[23:0], 8'h00};
               end
            end
         end

         S_ACK: begin
            if (w_tx_acc) begin
               w_tx_valid = 1'b0;
               w_state    = S_IDLE;
            end
         end

         default: w_state = S_IDLE;
      endcase

      // Registered off the next state so ready is high exactly while the
      // FSM sits in a byte-accepting state.
      w_rx_ready = (w_state == S_IDLE) || (w_state == S_ADDR) || (w_state == S_DATA);
   end

   assign bus.rx_ready              = r_rx_ready;
   assign bus.tx_data               = r_tx_data;
   assign bus.tx_valid              = r_tx_valid;
   assign bus.pause                 = r_pause;
   assign bus.externalMemoryControl = r_mc;
   assign bus.externalAddress       = r_addr;
   assign bus.externalData          = r_data;
   assign bus.externalReadMode      = r_rmode;
   assign bus.externalWriteMode     = r_wmode;

endmodule

// File: tb/tb_ext_mem_loader.sv
// ---------------------------------------------------------------------------
// tb_ext_mem_loader
// Table of commands with expected responses, memory strobes and pause state,
// plus hand sequences for reset, timeout, tx backpressure and reset during a
// command. Expected tx bytes are queued when a command is driven and popped
// as the loader emits them.
// ---------------------------------------------------------------------------
module tb_ext_mem_loader;

   localparam logic [2:0] M_NONE = 3'd0;
   localparam logic [2:0] M_WORD = 3'd3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   ext_mem_loader_if bus ();

   ext_mem_loader #(.TIMEOUT_CYCLES(16), .READ_LATENCY(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          n_vec   = 0;
   int          n_err   = 0;
   int          wr_seen = 0;
   int          rd_cyc  = 0;
   logic [7:0]  exp_q[$];
   logic [31:0] exp_waddr = 32'd0;
   logic [31:0] exp_wdata = 32'd0;

   typedef struct {
      logic [71:0] rx;     // command bytes, left-justified
      int          nrx;
      logic [31:0] tx;     // expected response bytes, left-justified
      int          ntx;
      logic [31:0] dout;   // memory read data presented
      bit          wr;
      bit          rd;
      logic [31:0] addr;
      logic [31:0] data;
      logic        pause;
   } vec_t;

   vec_t vt[11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitor: response scoreboard and memory-strobe bookkeeping.
   always @(negedge clk) begin
      if (rst) begin
         if (bus.tx_valid && bus.tx_ready) begin
            if (exp_q.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL tx_extra: got %h, expected no byte", bus.tx_data);
            end else begin
               chk("tx_byte", {24'h0, bus.tx_data}, {24'h0, exp_q.pop_front()});
            end
         end
         if (bus.externalWriteMode == M_WORD) begin
            wr_seen++;
            chk("wr_addr", bus.externalAddress, exp_waddr);
            chk("wr_data", bus.externalData, exp_wdata);
         end
         if (bus.externalReadMode == M_WORD) rd_cyc++;
         if (bus.externalReadMode == M_WORD && bus.externalWriteMode == M_WORD) begin
            n_vec++; n_err++;
            $display("FAIL both_modes: got WORD/WORD, expected at most one");
         end
         if (bus.tx_valid && bus.rx_ready) begin
            n_vec++; n_err++;
            $display("FAIL rx_during_tx: got rx_ready 1, expected 0");
         end
      end
   end

   // Called and returns #1 after a rising edge.
   task automatic send_byte(input logic [7:0] b);
      int k;
      k = 0;
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      @(negedge clk);
      while (!bus.rx_ready && k < 200) begin
         @(negedge clk);
         k++;
      end
      if (!bus.rx_ready) begin
         n_vec++; n_err++;
         $display("FAIL rx_accept: got rx_ready 0 for byte %h, expected 1", b);
      end
      @(posedge clk); #1;
      bus.rx_valid = 1'b0;
   endtask

   task automatic drain();
      int k;
      k = 0;
      @(negedge clk);
      while ((exp_q.size() != 0 || bus.tx_valid) && k < 500) begin
         @(negedge clk);
         k++;
      end
      if (exp_q.size() != 0 || bus.tx_valid) begin
         n_vec++; n_err++;
         $display("FAIL drain: got %0d bytes outstanding, expected 0", exp_q.size());
         exp_q.delete();
      end
      @(posedge clk); #1;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      wr_seen = 0;
      rd_cyc  = 0;
      bus.externalDataOut = v.dout;
      exp_waddr = v.addr;
      exp_wdata = v.data;
      for (int i = 0; i < v.ntx; i++) begin
         logic [7:0] t;
         t = v.tx[31-8*i -: 8];
         exp_q.push_back(t);
      end
      for (int i = 0; i < v.nrx; i++) send_byte(v.rx[71-8*i -: 8]);
      drain();
      chk($sformatf("v%0d_wr_strobes", idx), 32'(wr_seen), v.wr ? 32'd1 : 32'd0);
      chk($sformatf("v%0d_rd_cycles", idx), 32'(rd_cyc), v.rd ? 32'd2 : 32'd0);
      chk($sformatf("v%0d_pause", idx), 32'(bus.pause), 32'(v.pause));
      chk($sformatf("v%0d_memctl", idx), 32'(bus.externalMemoryControl), 32'(v.pause));
      if (v.wr || v.rd) chk($sformatf("v%0d_addr", idx), bus.externalAddress, v.addr);
      if (v.wr)         chk($sformatf("v%0d_data", idx), bus.externalData, v.data);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'd0);
      chk({tag, "_pause"},    32'(bus.pause), 32'd1);
      chk({tag, "_memctl"},   32'(bus.externalMemoryControl), 32'd1);
      chk({tag, "_addr"},     bus.externalAddress, 32'd0);
      chk({tag, "_data"},     bus.externalData, 32'd0);
      chk({tag, "_rmode"},    32'(bus.externalReadMode), 32'(M_NONE));
      chk({tag, "_wmode"},    32'(bus.externalWriteMode), 32'(M_NONE));
      chk({tag, "_tx_valid"}, 32'(bus.tx_valid), 32'd0);
      chk({tag, "_tx_data"},  32'(bus.tx_data), 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish, expected end of test");
      $fatal(1);
   end

   initial begin
      logic stable;
      int   k;
      bus.rx_data = 8'h00; bus.rx_valid = 1'b0;
      bus.tx_ready = 1'b1; bus.externalDataOut = 32'd0;

      //          rx bytes                         nrx tx            ntx dout          wr    rd    addr          data          pause
      vt[0]  = '{72'h57_00000400_08003FFB,        9, 32'h4B000000, 1, 32'h0,        1'b1, 1'b0, 32'h00000400, 32'h08003FFB, 1'b1};
      vt[1]  = '{72'h52_0000FFFC_00000000,        5, 32'h0000007B, 4, 32'h0000007B, 1'b0, 1'b1, 32'h0000FFFC, 32'h0,        1'b1};
      vt[2]  = '{72'h47_00000000_00000000,        1, 32'h4B000000, 1, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        1'b0};
      vt[3]  = '{72'h47_00000000_00000000,        1, 32'h4B000000, 1, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        1'b0};
      vt[4]  = '{72'h58_00000000_00000000,        1, 32'h3F000000, 1, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        1'b0};
      vt[5]  = '{72'h48_00000000_00000000,        1, 32'h4B000000, 1, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        1'b1};
      vt[6]  = '{72'h48_00000000_00000000,        1, 32'h4B000000, 1, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        1'b1};
      vt[7]  = '{72'h57_12345678_DEADBEEF,        9, 32'h4B000000, 1, 32'h0,        1'b1, 1'b0, 32'h12345678, 32'hDEADBEEF, 1'b1};
      vt[8]  = '{72'h52_12345678_00000000,        5, 32'hCAFEF00D, 4, 32'hCAFEF00D, 1'b0, 1'b1, 32'h12345678, 32'h0,        1'b1};
      vt[9]  = '{72'h00_00000000_00000000,        1, 32'h3F000000, 1, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        1'b1};
      vt[10] = '{72'h67_00000000_00000000,        1, 32'h3F000000, 1, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        1'b1};

      // Reset values, then ready rises one edge after release.
      #23;
      chk_reset("rst");
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
      chk("rx_ready_rise", 32'(bus.rx_ready), 32'd1);
      @(posedge clk); #1;

      for (int i = 0; i < 11; i++) run_vec(vt[i], i);

      // Release the processor, then an opcode re-halts it immediately and a
      // stalled address field times out after exactly 16 idle clocks.
      run_vec(vt[2], 100);
      wr_seen = 0;
      exp_q.push_back(8'h3F);
      send_byte(8'h57);
      chk("op_pause", 32'(bus.pause), 32'd1);
      chk("op_memctl", 32'(bus.externalMemoryControl), 32'd1);
      send_byte(8'h12);
      repeat (15) @(posedge clk);
      @(negedge clk);
      chk("tmo_early", 32'(bus.tx_valid), 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("tmo_fire", 32'(bus.tx_valid), 32'd1);
      chk("tmo_byte", 32'(bus.tx_data), 32'h3F);
      @(posedge clk); #1;
      drain();
      chk("tmo_no_write", 32'(wr_seen), 32'd0);
      chk("tmo_pause", 32'(bus.pause), 32'd1);
      run_vec(vt[1], 101);

      // Backpressure on a read response; a byte offered meanwhile is ignored.
      bus.tx_ready = 1'b0;
      bus.externalDataOut = 32'h11223344;
      wr_seen = 0; rd_cyc = 0;
      exp_q.push_back(8'h11); exp_q.push_back(8'h22);
      exp_q.push_back(8'h33); exp_q.push_back(8'h44);
      send_byte(8'h52); send_byte(8'h00); send_byte(8'h00);
      send_byte(8'h00); send_byte(8'h10);
      k = 0;
      while (!bus.tx_valid && k < 50) begin
         @(negedge clk);
         k++;
      end
      bus.rx_data = 8'h47; bus.rx_valid = 1'b1;
      stable = 1'b1;
      repeat (50) begin
         @(negedge clk);
         if (bus.tx_data !== 8'h11 || bus.tx_valid !== 1'b1 || bus.rx_ready !== 1'b0) stable = 1'b0;
      end
      chk("bp_hold", 32'(stable), 32'd1);
      chk("bp_rx_ready", 32'(bus.rx_ready), 32'd0);
      @(posedge clk); #1;
      bus.rx_valid = 1'b0;
      bus.tx_ready = 1'b1;
      drain();
      chk("bp_rd_cycles", 32'(rd_cyc), 32'd2);
      chk("bp_addr", bus.externalAddress, 32'h00000010);
      chk("bp_pause", 32'(bus.pause), 32'd1);

      // Reset after six bytes of a write.
      wr_seen = 0;
      send_byte(8'h57); send_byte(8'h00); send_byte(8'h00);
      send_byte(8'h04); send_byte(8'h00); send_byte(8'h08);
      #2 rst = 1'b0;
      #1 chk_reset("mid");
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (20) @(negedge clk);
      chk("mid_no_write", 32'(wr_seen), 32'd0);
      chk("mid_no_tx", 32'(bus.tx_valid), 32'd0);
      @(posedge clk); #1;
      run_vec(vt[0], 102);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
